// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard port bundle.
// master drives writes, reservations and read addresses; slave is the register file.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              rsvValid;
  logic [ADDR_W-1:0] rsvReg;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W:0]   busyCount;

  modport master (
    output regWrite, writeReg, writeData,
    output rsvValid, rsvReg,
    output readReg1, readReg2,
    input  readData1, readData2,
    input  busy1, busy2, busyCount
  );

  modport slave (
    input  regWrite, writeReg, writeData,
    input  rsvValid, rsvReg,
    input  readReg1, readReg2,
    output readData1, readData2,
    output busy1, busy2, busyCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file with busy-bit scoreboard.
// Issue reserves a destination, writeback writes data and releases it.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              wr_en;
  logic              rsv_en;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rbusy [2];

  // Register 0 swallows writes and reservations when hardwired to zero.
  assign wr_en = bus.regWrite && !reset &&
                 !((ZERO_REG != 0) && (bus.writeReg == '0));
  assign rsv_en = bus.rsvValid && !reset &&
                  !((ZERO_REG != 0) && (bus.rsvReg == '0));

  // Next busy vector: release first so a same-register reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[bus.writeReg] = 1'b0;
    if (rsv_en) busy_nxt[bus.rsvReg] = 1'b1;
  end

  // Population count of the next busy vector, registered below.
  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      count_nxt = count_nxt + CNT_W'(busy_nxt[i]);
  end

  // Storage, busy bits and count; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy  <= '0;
      count <= '0;
    end else begin
      if (wr_en) regs[bus.writeReg] <= bus.writeData;
      busy  <= busy_nxt;
      count <= count_nxt;
    end
  end

  assign raddr[0] = bus.readReg1;
  assign raddr[1] = bus.readReg2;

  // Read ports: stored value, optional same-cycle forward, zero reg last.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[raddr[p]];
      rbusy[p] = busy[raddr[p]];
      if ((BYPASS != 0) && wr_en && (bus.writeReg == raddr[p])) begin
        rdata[p] = bus.writeData;
        rbusy[p] = rsv_en && (bus.rsvReg == raddr[p]);
      end
      if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign bus.readData1 = rdata[0];
  assign bus.readData2 = rdata[1];
  assign bus.busy1     = rbusy[0];
  assign bus.busy2     = rbusy[1];
  assign bus.busyCount = count;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one BYPASS=1 and one BYPASS=0 instance
// driven identically and checked against an array-based model.
`timescale 1ns/100ps
module tb_regfile_scoreboard;
  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        rsvValid;
  logic [4:0]  rsvReg;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;

  int vectors;
  int miscompares;

  bit [31:0] mreg [32];
  bit [31:0] mbusy;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) ia ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) ib ();

  assign ia.regWrite  = regWrite;
  assign ia.writeReg  = writeReg;
  assign ia.writeData = writeData;
  assign ia.rsvValid  = rsvValid;
  assign ia.rsvReg    = rsvReg;
  assign ia.readReg1  = readReg1;
  assign ia.readReg2  = readReg2;
  assign ib.regWrite  = regWrite;
  assign ib.writeReg  = writeReg;
  assign ib.writeData = writeData;
  assign ib.rsvValid  = rsvValid;
  assign ib.rsvReg    = rsvReg;
  assign ib.readReg1  = readReg1;
  assign ib.readReg2  = readReg2;

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
  ) u_byp (
    .clk(clk), .reset(reset), .bus(ia)
  );

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)
  ) u_nobyp (
    .clk(clk), .reset(reset), .bus(ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mbusy = '0;
  endfunction

  function automatic bit wr_hits(logic [4:0] a);
    return !reset && regWrite && writeReg == a;
  endfunction

  function automatic logic [31:0] exp_data(logic [4:0] a, bit byp);
    if (a == 0) return '0;
    if (byp && wr_hits(a)) return writeData;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(logic [4:0] a, bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_hits(a)) return rsvValid && rsvReg == a;
    return mbusy[a];
  endfunction

  function automatic void model_edge();
    if (reset) return;
    if (regWrite && writeReg != 0) begin
      mreg[writeReg] = writeData;
      mbusy[writeReg] = 1'b0;
    end
    if (rsvValid && rsvReg != 0) mbusy[rsvReg] = 1'b1;
  endfunction

  task automatic chk(input string tag);
    logic [31:0] o1, o2, e1, e2;
    logic        ob1, ob2, eb1, eb2;
    logic [5:0]  oc, ec;
    ec = 6'($countones(mbusy));
    for (int d = 0; d < 2; d++) begin
      e1  = exp_data(readReg1, d == 0);
      e2  = exp_data(readReg2, d == 0);
      eb1 = exp_busy(readReg1, d == 0);
      eb2 = exp_busy(readReg2, d == 0);
      o1  = (d == 0) ? ia.readData1 : ib.readData1;
      o2  = (d == 0) ? ia.readData2 : ib.readData2;
      ob1 = (d == 0) ? ia.busy1 : ib.busy1;
      ob2 = (d == 0) ? ia.busy2 : ib.busy2;
      oc  = (d == 0) ? ia.busyCount : ib.busyCount;
      vectors++;
      assert (o1 === e1) else begin
        miscompares++;
        $error("FAIL %s byp=%0d readData1 got %h exp %h", tag, d == 0, o1, e1);
      end
      vectors++;
      assert (o2 === e2) else begin
        miscompares++;
        $error("FAIL %s byp=%0d readData2 got %h exp %h", tag, d == 0, o2, e2);
      end
      vectors++;
      assert (ob1 === eb1) else begin
        miscompares++;
        $error("FAIL %s byp=%0d busy1 got %b exp %b", tag, d == 0, ob1, eb1);
      end
      vectors++;
      assert (ob2 === eb2) else begin
        miscompares++;
        $error("FAIL %s byp=%0d busy2 got %b exp %b", tag, d == 0, ob2, eb2);
      end
      vectors++;
      assert (oc === ec) else begin
        miscompares++;
        $error("FAIL %s byp=%0d busyCount got %0d exp %0d", tag, d == 0, oc, ec);
      end
    end
  endtask

  task automatic step(input string tag);
    #3;
    chk(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    regWrite  = 1'b0;
    writeReg  = '0;
    writeData = '0;
    rsvValid  = 1'b0;
    rsvReg    = '0;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    model_clear();
    #1;
    chk(tag);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    model_clear();
    idle();
    readReg1 = 5'd3;
    readReg2 = 5'd9;

    // Reset held across edges with write/reserve active: all ignored.
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h1111_2222;
    rsvValid = 1'b1; rsvReg = 5'd9;
    step("rst_hold");
    step("rst_hold2");
    idle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      step("rst_sweep");
    end

    // Write r5, then attempt r0; reserve r0.
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
    step("wr_r5");
    writeReg = 5'd0; writeData = 32'h1234_5678;
    step("wr_r0");
    idle();
    readReg1 = 5'd5; readReg2 = 5'd0;
    rsvValid = 1'b1; rsvReg = 5'd0;
    step("rd_r5_r0");
    idle();
    step("rsv_r0");

    // Scoreboard reserve / release.
    rsvValid = 1'b1; rsvReg = 5'd3;
    step("rsv_r3");
    rsvReg = 5'd7;
    step("rsv_r7");
    idle();
    readReg1 = 5'd3; readReg2 = 5'd7;
    step("busy_2");
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h55;
    step("rel_r3");
    idle();
    step("busy_1");

    // Bypass on r9 after reserving it.
    rsvValid = 1'b1; rsvReg = 5'd9;
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h0BAD_F00D;
    step("r9_seed");
    idle();
    rsvValid = 1'b1; rsvReg = 5'd9;
    step("rsv_r9");
    idle();
    readReg1 = 5'd9; readReg2 = 5'd9;
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'hA5A5_A5A5;
    step("bypass_r9");
    idle();
    step("after_r9");

    // Write and reserve the same register.
    readReg1 = 5'd12; readReg2 = 5'd7;
    regWrite = 1'b1; writeReg = 5'd12; writeData = 32'h77;
    rsvValid = 1'b1; rsvReg = 5'd12;
    step("collide_r12");
    idle();
    step("after_r12");
    regWrite = 1'b1; writeReg = 5'd12; writeData = 32'h99;
    rsvValid = 1'b1; rsvReg = 5'd12;
    step("collide_r12_busy");
    idle();
    step("after_r12_busy");

    // Reserve r1..r4, then reset between edges.
    for (int i = 1; i <= 4; i++) begin
      rsvValid = 1'b1; rsvReg = 5'(i);
      regWrite = 1'b1; writeReg = 5'(i); writeData = $urandom;
      step("rsv_r1_4");
    end
    idle();
    readReg1 = 5'd1; readReg2 = 5'd4;
    step("busy_4");
    pulse_reset("mid_reset");
    step("post_reset_a");
    readReg1 = 5'd2; readReg2 = 5'd3;
    step("post_reset_b");

    // Random traffic with a bias towards a few registers.
    for (int n = 0; n < 400; n++) begin
      regWrite  = 1'($urandom);
      writeData = $urandom;
      rsvValid  = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        writeReg = 5'($urandom_range(0, 7));
        rsvReg   = 5'($urandom_range(0, 7));
        readReg1 = 5'($urandom_range(0, 7));
        readReg2 = 5'($urandom_range(0, 7));
      end else begin
        writeReg = 5'($urandom);
        rsvReg   = 5'($urandom);
        readReg1 = 5'($urandom);
        readReg2 = 5'($urandom);
      end
      if (n == 200) pulse_reset("rand_reset");
      step("random");
    end

    // Fill the scoreboard completely.
    idle();
    for (int i = 0; i < 32; i++) begin
      rsvValid = 1'b1; rsvReg = 5'(i);
      readReg1 = 5'(i); readReg2 = 5'(31 - i);
      step("fill");
    end
    idle();
    step("full");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
